// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down counter with terminal-count pulse, optional auto-reload and a run/idle/done FSM
module sync_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             last;
  assign last  = count_q == WIDTH'(1);
  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = state_q == RUN;
  // next state: load wins over counting; terminal count either reloads or parks in DONE
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = load_val != '0 ? RUN : IDLE;
    end else if (state_q == RUN && en && count_q != '0) begin
      tc_d    = last;
      count_d = !last ? count_q - WIDTH'(1) : auto_reload ? reload_q : '0;
      state_d = last && !auto_reload ? DONE : RUN;
    end
  end
  // state, count, reload and tc registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end
endmodule
